lsu_mem_ctrl: RTL and testbench

Load/store controller between the MEM pipeline stage and the byte-addressable data memory. It accepts one load/store request at a time on a valid/ready handshake and checks funct3 legality and address range. Aligned accesses are issued as a single memory beat. Misaligned halfword/word accesses are split into sequential byte beats, and load bytes are reassembled with sign or zero extension. It drives the data memory's wr_en/rd_en/addr/wr_data/funct3 port and samples its combinational rd_data.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_load_ext.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states,
// access-size and legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Access size in bytes from funct3[1:0]; code 3 is illegal anyway.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    size_of = 3'd1;
      2'd1:    size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) is_legal = funct3 inside {F3_B, F3_H, F3_W};
    else    is_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of assembled load data by the request funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_BU:   o_data = {24'b0, i_data[7:0]};
      F3_HU:   o_data = {16'b0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between MEM stage and byte-addressable data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rd_data,
  output state_e            dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, and req_* are
  // sampled only on that edge.

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_beat;
  logic [1:0]        r_last;
  logic [31:0]       r_asm;
  logic              r_err;
  logic              r_split;

  logic [2:0]        w_size;
  logic [ADDR_W:0]   w_end;
  logic              w_oor;
  logic              w_misal;
  logic              w_req_err;
  logic              w_accept;
  logic              w_last;
  logic [31:0]       w_ext;

  assign w_size   = size_of(req_funct3);
  // One extra bit so an access straddling the top of the address space cannot wrap.
  assign w_end    = {1'b0, req_addr} + (ADDR_W+1)'(w_size) - (ADDR_W+1)'(1);
  assign w_oor    = w_end >= (ADDR_W+1)'(MEM_BYTES);
  assign w_misal  = ((w_size == 3'd2) && req_addr[0]) ||
                    ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_err = !is_legal(req_we, req_funct3) || w_oor || w_misal;
`else
  assign w_req_err = !is_legal(req_we, req_funct3) || w_oor;
`endif
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_last    = !r_split || (r_beat == r_last);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_funct3  = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_wr_en = r_we;
        mem_rd_en = !r_we;
        if (r_split) begin
          mem_addr    = r_addr + ADDR_W'(r_beat);
          mem_funct3  = r_we ? F3_B : F3_BU;
          mem_wr_data = {24'b0, r_wdata[{r_beat, 3'b000} +: 8]};
        end else begin
          mem_addr    = r_addr;
          mem_funct3  = r_funct3;
          mem_wr_data = r_wdata;
        end
        if (w_last) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_beat   <= '0;
      r_last   <= '0;
      r_asm    <= '0;
      r_err    <= 1'b0;
      r_split  <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_beat   <= '0;
      r_last   <= w_size[1:0] - 2'd1;
      r_asm    <= '0;
      r_err    <= w_req_err;
      r_split  <= w_misal;
    end else if (r_state == ACCESS) begin
      r_beat <= r_beat + 2'd1;
      // Split loads fill the assembly register one little-endian byte per beat.
      if (!r_we) begin
        if (r_split) r_asm[{r_beat, 3'b000} +: 8] <= mem_rd_data[7:0];
        else         r_asm <= mem_rd_data;
      end
    end
  end

  lsu_load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_data   (r_asm),
    .o_data   (w_ext)
  );

  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_we && !r_err) ? w_ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: transaction-level model predicts the
// per-cycle output schedule; literal expectations pin the model's results.
module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 4096;
  localparam int SW        = 104;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [SW-1:0] IDLE_SNAP = {1'b1, 103'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [2:0]  mem_funct3;
  lsu_pkg::state_e dbg_state;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic int tb_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0)      return 1;
    else if (f3[1:0] == 2'd1) return 2;
    else                      return 4;
  endfunction

  // ---------------- data memory ----------------
  logic [7:0]  mem_b [0:MEM_BYTES-1];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (i < tb_size(mem_funct3) && (mem_addr + 32'(i)) < 32'(MEM_BYTES))
          mem_b[mem_addr[11:0] + 12'(i)] <= mem_wr_data[8*i +: 8];
    if (bd_we) mem_b[bd_addr] <= bd_data;
  end

  always_comb begin
    mem_rd_data = '0;
    for (int i = 0; i < 4; i++)
      if ((mem_addr + 32'(i)) < 32'(MEM_BYTES))
        mem_rd_data[8*i +: 8] = mem_b[mem_addr[11:0] + 12'(i)];
  end

  // ---------------- model ----------------
  logic [7:0]    ref_mem [0:MEM_BYTES-1];
  logic [SW-1:0] exp_q[$];

  function automatic logic [SW-1:0] snap(input logic rdy, input logic wr, input logic rd,
      input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
      input logic rv, input logic [31:0] rdat, input logic rerr);
    return {rdy, wr, rd, addr, wd, f3, rv, rdat, rerr};
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b101:  return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Pushes the expected outputs for cycles 1..N after acceptance.
  task automatic model_push(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int size;
    bit legal, err, misal;
    logic [31:0] v;
    size  = tb_size(f3);
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || ((longint'(addr) + longint'(size) - 1) >= longint'(MEM_BYTES));
    misal = (addr % size) != 0;
    if (TRAP && misal) err = 1'b1;
    if (err) begin
      exp_q.push_back(snap(0, 0, 0, 0, 0, 0, 1, 0, 1));
    end else begin
      if (!misal)
        exp_q.push_back(snap(0, we, !we, addr, wdata, f3, 0, 0, 0));
      else
        for (int k = 0; k < size; k++)
          exp_q.push_back(snap(0, we, !we, addr + 32'(k), {24'b0, wdata[8*k +: 8]},
                               we ? 3'b000 : 3'b100, 0, 0, 0));
      v = '0;
      for (int k = 0; k < size; k++) begin
        if (we) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
        else    v[8*k +: 8] = ref_mem[int'(addr) + k];
      end
      exp_q.push_back(snap(0, 0, 0, 0, 0, 0, 1, we ? 32'h0 : extend(f3, v), 0));
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  int checks = 0, errors = 0, cyc = 0, resp_cnt = 0, resp_cyc = 0;
  logic [31:0]   last_rdata = '0;
  logic          last_err = 1'b0;
  logic [SW-1:0] cmp_e, cmp_a;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      cmp_e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_SNAP;
      cmp_a = {req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_funct3,
               resp_valid, resp_rdata, resp_err};
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d got=%h want=%h", cyc, cmp_a, cmp_e);
      end
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc   = cyc;
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  int acc_cyc = 0;

  task automatic preload(input int a, input logic [7:0] d);
    bd_addr = 12'(a);
    bd_data = d;
    bd_we   = 1'b1;
    ref_mem[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold);
    int n;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    if (exp_q.size() != 0) begin
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
      if (exp_q.size() != 0) begin
        checks++; errors++;
        $display("FAIL issue_timeout pending=%0d want=0", exp_q.size());
        exp_q.delete();
      end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    model_push(we, f3, addr, wdata);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
    int n, c0;
    c0 = resp_cnt;
    n  = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk({name, "_resp_cnt"}, 32'(resp_cnt - c0), 32'd1);
    chk({name, "_rdata"}, last_rdata, exp_rdata);
    chk({name, "_err"}, {31'b0, last_err}, {31'b0, exp_err});
    chk({name, "_lat"}, 32'(resp_cyc - acc_cyc), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, acc1;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    preload(32'h100, 8'h80); preload(32'h101, 8'h7F); preload(32'h102, 8'h01);
    preload(32'h103, 8'hFF); preload(32'h104, 8'h12); preload(32'hFFF, 8'h5A);
    for (int a = 32'h301; a <= 32'h304; a++) preload(a, 8'h00);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_en", {30'b0, mem_wr_en, mem_rd_en}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 3'b000, 32'h100, 0, 0);
    wait_done("lb_100", 32'hFFFFFF80, 0, 2);
    issue(0, 3'b010, 32'h101, 0, 0);
    wait_done("lw_101", TRAP ? 32'h0 : 32'h12FF017F, TRAP, TRAP ? 1 : 5);
    issue(1, 3'b001, 32'h203, 32'h0000BEEF, 0);
    wait_done("sh_203", 32'h0, TRAP, TRAP ? 1 : 3);
    issue(0, 3'b101, 32'h203, 0, 0);
    wait_done("lhu_203", TRAP ? 32'h0 : 32'h0000BEEF, TRAP, TRAP ? 1 : 3);
    issue(0, 3'b011, 32'h10, 0, 0);
    wait_done("ld_f3_011", 32'h0, 1, 1);
    issue(1, 3'b100, 32'h10, 32'h55, 0);
    wait_done("st_f3_100", 32'h0, 1, 1);
    issue(0, 3'b010, 32'hFFE, 0, 0);
    wait_done("lw_ffe", 32'h0, 1, 1);
    issue(0, 3'b000, 32'hFFF, 0, 0);
    wait_done("lb_fff", 32'h0000005A, 0, 2);
    issue(0, 3'b001, 32'h102, 0, 0);
    wait_done("lh_102", 32'hFFFFFF01, 0, 2);
    issue(0, 3'b100, 32'h100, 0, 0);
    wait_done("lbu_100", 32'h00000080, 0, 2);
    issue(0, 3'b001, 32'h103, 0, 0);
    wait_done("lh_103", TRAP ? 32'h0 : 32'h000012FF, TRAP, TRAP ? 1 : 3);

    // Back-to-back with req_valid held high across both requests.
    issue(1, 3'b010, 32'h40, 32'hDEADBEEF, 1);
    acc1 = acc_cyc;
    issue(0, 3'b010, 32'h40, 0, 0);
    chk("b2b_gap", 32'(acc_cyc - acc1), 32'd3);
    wait_done("b2b_lw_40", 32'hDEADBEEF, 0, 2);

    // Reset in the middle of a split store.
    c0 = resp_cnt;
    issue(1, 3'b010, 32'h301, 32'hA1B2C3D4, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_outs", {mem_wr_en, mem_rd_en, resp_valid, resp_err, 28'b0} | mem_addr | resp_rdata, 32'd0);
    chk("abort_resp_cnt", 32'(resp_cnt - c0), TRAP ? 32'd1 : 32'd0);
    rst_n = 1'b1;
    chk("abort_m301", {24'b0, mem_b[12'h301]}, TRAP ? 32'h00 : 32'hD4);
    chk("abort_m302", {24'b0, mem_b[12'h302]}, TRAP ? 32'h00 : 32'hC3);
    chk("abort_m303", {24'b0, mem_b[12'h303]}, 32'h00);
    chk("abort_m304", {24'b0, mem_b[12'h304]}, 32'h00);
    ref_mem[32'h303] = 8'h00;
    ref_mem[32'h304] = 8'h00;
    @(posedge clk); #1;
    issue(0, 3'b100, 32'h301, 0, 0);
    wait_done("lbu_301", TRAP ? 32'h0 : 32'h000000D4, 0, 2);
    issue(0, 3'b000, 32'h302, 0, 0);
    wait_done("lb_302", TRAP ? 32'h0 : 32'hFFFFFFC3, 0, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
